// File: rtl/decode_stage_pkg.sv
// Datapath widths, major opcode map (instr[6:2]) and SYSTEM/funct7 encodings for the decode stage.
package decode_stage_pkg;
    localparam int XLEN = 32;
    localparam int ALEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [4:0] {
        OPC_LOAD      = 5'b00000,
        OPC_MISC_MEM  = 5'b00011,
        OPC_OP_IMM    = 5'b00100,
        OPC_AUIPC     = 5'b00101,
        OPC_OP_IMM_32 = 5'b00110,
        OPC_STORE     = 5'b01000,
        OPC_OP        = 5'b01100,
        OPC_LUI       = 5'b01101,
        OPC_OP_32     = 5'b01110,
        OPC_BRANCH    = 5'b11000,
        OPC_JALR      = 5'b11001,
        OPC_JAL       = 5'b11011,
        OPC_SYSTEM    = 5'b11100
    } opcode_e;

    localparam logic [11:0] SYS_ECALL  = 12'h000;
    localparam logic [11:0] SYS_EBREAK = 12'h001;
    localparam logic [11:0] SYS_MRET   = 12'h302;
    localparam logic [11:0] SYS_WFI    = 12'h105;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;
endpackage

// File: rtl/trap_causes.sv
// Trap cause codes reported alongside decode_exception.
package trap_causes;
    localparam logic [3:0] INSTR_ACCESS_FAULT  = 4'd1;
    localparam logic [3:0] ILLEGAL_INSTRUCTION = 4'd2;
endpackage

// File: rtl/decode_illegal_check.sv
// Flags encodings the core cannot execute (funct7 0x01 legal only with DECODE_MULDIV_EN).
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever word fetch presents.
module decode_illegal_check
    import decode_stage_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic            illegal
);
    opcode_e     opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] sys_imm;
    logic        f7_ok;
    logic        unused_fields;

    assign opc           = opcode_e'(instr[6:2]);
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign sys_imm       = instr[31:20];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

`ifdef DECODE_MULDIV_EN
    assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
`else
    assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
`endif

    always_comb begin
        illegal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL,
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_MISC_MEM: illegal = 1'b0;
            OPC_JALR:             illegal = (f3 != 3'd0);
            OPC_BRANCH:           illegal = (f3 == 3'd2) || (f3 == 3'd3);
            OPC_LOAD:             illegal = (f3 == 3'd7);
            OPC_STORE:            illegal = f3[2];
            OPC_OP, OPC_OP_32:    illegal = !f7_ok;
            OPC_SYSTEM:           illegal = (f3 == 3'd0) &&
                                            !((sys_imm == SYS_ECALL) || (sys_imm == SYS_EBREAK) ||
                                              (sys_imm == SYS_MRET)  || (sys_imm == SYS_WFI));
            default:              illegal = 1'b1;
        endcase
        // Compressed/short encodings are not supported at all.
        if (instr[1:0] != 2'b11) illegal = 1'b1;
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, classification, regfile read, registered towards exec (DECODE_MULDIV_EN enables M ext).
// Latency: 1 cycle from accepted fetch word to valid decode output.
// Backpressure: holds output while exec stalls (refreshing operands from writeback); flush drops everything.
module decode_stage
    import decode_stage_pkg::*;
    import trap_causes::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prev_stalled,
    output logic            stall_prev,
    input  logic            next_stalled,
    output logic            stall_next,
    input  logic            exec_pipeline_flush,
    input  logic [ILEN-1:0] fetch_instruction,
    input  logic [ALEN-1:0] fetch_instruction_addr,
    input  logic [ALEN-1:0] fetch_instruction_next_addr,
    input  logic            fetch_exception,
    input  logic [3:0]      fetch_trap_cause,
    output logic [4:0]      regfile_rs1_sel,
    output logic [4:0]      regfile_rs2_sel,
    input  logic [XLEN-1:0] regfile_rs1_data,
    input  logic [XLEN-1:0] regfile_rs2_data,
    input  logic            writeback_en,
    input  logic [4:0]      writeback_sel,
    input  logic [XLEN-1:0] writeback_data,
    output logic            decode_exception,
    output logic [3:0]      decode_trap_cause,
    output logic            decode_is_jump,
    output logic            decode_is_reg_write,
    output logic [ILEN-1:0] decode_original_instruction,
    output logic [ALEN-1:0] decode_instruction_addr,
    output logic [ALEN-1:0] decode_instruction_next_addr,
    output logic [4:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [11:0]     i_imm,
    output logic [11:0]     s_imm,
    output logic [11:0]     b_imm,
    output logic [19:0]     u_imm,
    output logic [19:0]     j_imm,
    output logic [XLEN-1:0] decode_rs1_data,
    output logic [XLEN-1:0] decode_rs2_data,
    output logic            rs1_mul_sign,
    output logic            rs2_mul_sign
);
    logic            valid_q, valid_d;
    logic            exc_q, exc_d;
    logic [3:0]      cause_q, cause_d;
    logic            jump_q, jump_d;
    logic            rw_q, rw_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [ALEN-1:0] addr_q, addr_d;
    logic [ALEN-1:0] next_addr_q, next_addr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic            accept;
    logic            illegal;
    logic            f_exc;
    logic            f_is_jump;
    logic            f_is_rw;
    opcode_e         f_opc;
    logic [2:0]      f_f3;
    logic [4:0]      f_rs1, f_rs2, held_rs1, held_rs2;
    logic [XLEN-1:0] rs1_cap, rs2_cap;

    decode_illegal_check u_illegal (
        .instr   (fetch_instruction),
        .illegal (illegal)
    );

    assign stall_prev = valid_q && next_stalled;
    assign stall_next = !valid_q;
    assign accept     = !prev_stalled && !stall_prev && !exec_pipeline_flush;

    assign f_opc           = opcode_e'(fetch_instruction[6:2]);
    assign f_f3            = fetch_instruction[14:12];
    assign f_rs1           = fetch_instruction[19:15];
    assign f_rs2           = fetch_instruction[24:20];
    assign regfile_rs1_sel = f_rs1;
    assign regfile_rs2_sel = f_rs2;
    assign f_exc           = fetch_exception || illegal;

    // Regfile is written at the same edge we capture, so bypass the retiring value.
    assign rs1_cap = (f_rs1 == 5'd0) ? '0 :
                     (writeback_en && writeback_sel == f_rs1) ? writeback_data : regfile_rs1_data;
    assign rs2_cap = (f_rs2 == 5'd0) ? '0 :
                     (writeback_en && writeback_sel == f_rs2) ? writeback_data : regfile_rs2_data;

    always_comb begin
        f_is_jump = 1'b0;
        f_is_rw   = 1'b0;
        case (f_opc)
            OPC_JAL, OPC_JALR: begin f_is_jump = 1'b1; f_is_rw = 1'b1; end
            OPC_BRANCH:        f_is_jump = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_OP,
            OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32: f_is_rw = 1'b1;
            OPC_SYSTEM: begin
                f_is_rw   = (f_f3 != 3'd0);
                f_is_jump = (f_f3 == 3'd0) && (fetch_instruction[31:20] == SYS_MRET);
            end
            default: ;
        endcase
    end

    assign held_rs1 = instr_q[19:15];
    assign held_rs2 = instr_q[24:20];

    always_comb begin
        valid_d     = valid_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        jump_d      = jump_q;
        rw_d        = rw_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        if (exec_pipeline_flush) begin
            valid_d = 1'b0;
            exc_d   = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            instr_d     = fetch_instruction;
            addr_d      = fetch_instruction_addr;
            next_addr_d = fetch_instruction_next_addr;
            exc_d       = f_exc;
            cause_d     = fetch_exception ? fetch_trap_cause :
                          illegal         ? ILLEGAL_INSTRUCTION : 4'd0;
            jump_d      = f_is_jump && !f_exc;
            rw_d        = f_is_rw && !f_exc;
            rs1_d       = rs1_cap;
            rs2_d       = rs2_cap;
        end else if (valid_q && next_stalled) begin
            // Holding: the producer of a held operand may retire meanwhile.
            if (writeback_en && writeback_sel == held_rs1 && held_rs1 != 5'd0) rs1_d = writeback_data;
            if (writeback_en && writeback_sel == held_rs2 && held_rs2 != 5'd0) rs2_d = writeback_data;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            exc_q       <= 1'b0;
            cause_q     <= '0;
            jump_q      <= 1'b0;
            rw_q        <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            exc_q       <= exc_d;
            cause_q     <= cause_d;
            jump_q      <= jump_d;
            rw_q        <= rw_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
        end
    end

    assign decode_exception             = exc_q;
    assign decode_trap_cause            = cause_q;
    assign decode_is_jump               = jump_q;
    assign decode_is_reg_write          = rw_q;
    assign decode_original_instruction  = instr_q;
    assign decode_instruction_addr      = addr_q;
    assign decode_instruction_next_addr = next_addr_q;
    assign decode_rs1_data              = rs1_q;
    assign decode_rs2_data              = rs2_q;

    assign opcode = instr_q[6:2];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];
    assign i_imm  = instr_q[31:20];
    assign s_imm  = {instr_q[31:25], instr_q[11:7]};
    assign b_imm  = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
    assign u_imm  = instr_q[31:12];
    assign j_imm  = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};

`ifdef DECODE_MULDIV_EN
    // MULHU treats rs1 unsigned; only MUL/MULH treat rs2 signed.
    assign rs1_mul_sign = rs1_q[XLEN-1] && (instr_q[14:12] != 3'd3);
    assign rs2_mul_sign = rs2_q[XLEN-1] && (instr_q[14:13] == 2'b00);
`else
    assign rs1_mul_sign = 1'b0;
    assign rs2_mul_sign = 1'b0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, hold/refresh, illegal table, faults, flush, muldiv, async reset.
module tb_decode_stage;
    import decode_stage_pkg::*;
    import trap_causes::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            prev_stalled, stall_prev, next_stalled, stall_next, exec_pipeline_flush;
    logic [ILEN-1:0] fetch_instruction;
    logic [ALEN-1:0] fetch_instruction_addr, fetch_instruction_next_addr;
    logic            fetch_exception;
    logic [3:0]      fetch_trap_cause;
    logic [4:0]      regfile_rs1_sel, regfile_rs2_sel;
    logic [XLEN-1:0] regfile_rs1_data, regfile_rs2_data;
    logic            writeback_en;
    logic [4:0]      writeback_sel;
    logic [XLEN-1:0] writeback_data;
    logic            decode_exception, decode_is_jump, decode_is_reg_write;
    logic [3:0]      decode_trap_cause;
    logic [ILEN-1:0] decode_original_instruction;
    logic [ALEN-1:0] decode_instruction_addr, decode_instruction_next_addr;
    logic [4:0]      opcode, rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [11:0]     i_imm, s_imm, b_imm;
    logic [19:0]     u_imm, j_imm;
    logic [XLEN-1:0] decode_rs1_data, decode_rs2_data;
    logic            rs1_mul_sign, rs2_mul_sign;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .prev_stalled(prev_stalled), .stall_prev(stall_prev),
        .next_stalled(next_stalled), .stall_next(stall_next),
        .exec_pipeline_flush(exec_pipeline_flush),
        .fetch_instruction(fetch_instruction),
        .fetch_instruction_addr(fetch_instruction_addr),
        .fetch_instruction_next_addr(fetch_instruction_next_addr),
        .fetch_exception(fetch_exception), .fetch_trap_cause(fetch_trap_cause),
        .regfile_rs1_sel(regfile_rs1_sel), .regfile_rs2_sel(regfile_rs2_sel),
        .regfile_rs1_data(regfile_rs1_data), .regfile_rs2_data(regfile_rs2_data),
        .writeback_en(writeback_en), .writeback_sel(writeback_sel), .writeback_data(writeback_data),
        .decode_exception(decode_exception), .decode_trap_cause(decode_trap_cause),
        .decode_is_jump(decode_is_jump), .decode_is_reg_write(decode_is_reg_write),
        .decode_original_instruction(decode_original_instruction),
        .decode_instruction_addr(decode_instruction_addr),
        .decode_instruction_next_addr(decode_instruction_next_addr),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm),
        .decode_rs1_data(decode_rs1_data), .decode_rs2_data(decode_rs2_data),
        .rs1_mul_sign(rs1_mul_sign), .rs2_mul_sign(rs2_mul_sign)
    );

    // Register file model: written by writeback at the clock edge, read combinationally.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (writeback_en && writeback_sel != 5'd0) begin
            rf[writeback_sel] <= writeback_data;
        end
    end
    assign regfile_rs1_data = rf[regfile_rs1_sel];
    assign regfile_rs2_data = rf[regfile_rs2_sel];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic exc, input logic [3:0] cause);
        fetch_instruction           = ins;
        fetch_instruction_addr      = pc;
        fetch_instruction_next_addr = pc + 32'd4;
        fetch_exception             = exc;
        fetch_trap_cause            = cause;
        prev_stalled                = 1'b0;
        tick();
        prev_stalled                = 1'b1;
        fetch_exception             = 1'b0;
        fetch_trap_cause            = 4'd0;
    endtask

    task automatic wb(input logic [4:0] sel, input logic [31:0] data);
        writeback_en   = 1'b1;
        writeback_sel  = sel;
        writeback_data = data;
        tick();
        writeback_en   = 1'b0;
    endtask

    // Illegal/classification table: instruction, exception, jump, reg_write.
    logic [31:0] t_ins [15] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_007F, 32'h0000_2063,
                                32'h0000_7003, 32'h0000_4023, 32'h0000_1067, 32'h0020_0073,
                                32'h0000_0063, 32'h0000_006F, 32'h3020_0073, 32'h0000_0073,
                                32'h0000_2073, 32'h4003_03B3, 32'h0803_03B3};
    logic        t_exc [15] = '{1,1,1,1, 1,1,1,1, 0,0,0,0, 0,0,1};
    logic        t_jmp [15] = '{0,0,0,0, 0,0,0,0, 1,1,1,0, 0,0,0};
    logic        t_rw  [15] = '{0,0,0,0, 0,0,0,0, 0,1,0,0, 1,1,0};

    initial begin
        rst_n = 1'b0;
        prev_stalled = 1'b1; next_stalled = 1'b0; exec_pipeline_flush = 1'b0;
        fetch_instruction = '0; fetch_instruction_addr = '0; fetch_instruction_next_addr = '0;
        fetch_exception = 1'b0; fetch_trap_cause = '0;
        writeback_en = 1'b0; writeback_sel = '0; writeback_data = '0;

        #2;
        check("rst_stall_next", 32'(stall_next), 32'd1);
        check("rst_stall_prev", 32'(stall_prev), 32'd0);
        check("rst_exception",  32'(decode_exception), 32'd0);
        check("rst_reg_write",  32'(decode_is_reg_write), 32'd0);
        check("rst_instr",      decode_original_instruction, 32'd0);
        check("rst_rs1_data",   decode_rs1_data, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // ADDI x5,x0,7
        issue(32'h0070_0293, 32'h0000_0100, 1'b0, 4'd0);
        check("addi_stall_next", 32'(stall_next), 32'd0);
        check("addi_opcode",     32'(opcode), 32'h04);
        check("addi_rd",         32'(rd), 32'd5);
        check("addi_i_imm",      32'(i_imm), 32'h007);
        check("addi_reg_write",  32'(decode_is_reg_write), 32'd1);
        check("addi_exception",  32'(decode_exception), 32'd0);
        check("addi_jump",       32'(decode_is_jump), 32'd0);
        check("addi_next_addr",  decode_instruction_next_addr, 32'h0000_0104);
        tick();
        check("bubble_stall_next", 32'(stall_next), 32'd1);

        // Hold ADD x7,x6,x6 three cycles while x6 retires 0xDEAD
        wb(5'd6, 32'h0000_1111);
        next_stalled = 1'b1;
        issue(32'h0063_03B3, 32'h0000_0200, 1'b0, 4'd0);
        check("hold_stall_prev", 32'(stall_prev), 32'd1);
        check("hold_cap_rs1",    decode_rs1_data, 32'h0000_1111);
        fetch_instruction = 32'h0070_0293;
        prev_stalled      = 1'b0;
        wb(5'd6, 32'h0000_DEAD);
        tick();
        tick();
        prev_stalled = 1'b1;
        check("hold_rd_kept",  32'(rd), 32'd7);
        check("hold_rs1_data", decode_rs1_data, 32'h0000_DEAD);
        check("hold_rs2_data", decode_rs2_data, 32'h0000_DEAD);
        check("hold_valid",    32'(stall_next), 32'd0);
        next_stalled = 1'b0;
        tick();
        check("release_drain", 32'(stall_next), 32'd1);

        // ADD x8,x0,x9 with x9 retiring in the capture cycle, then x0 writeback during hold
        writeback_en = 1'b1; writeback_sel = 5'd9; writeback_data = 32'h0000_0077;
        issue(32'h0090_0433, 32'h0000_0300, 1'b0, 4'd0);
        writeback_en = 1'b0;
        check("bypass_rs2", decode_rs2_data, 32'h0000_0077);
        check("bypass_rs1_x0", decode_rs1_data, 32'd0);
        next_stalled = 1'b1;
        wb(5'd0, 32'h0000_FFFF);
        check("hold_x0_rs1", decode_rs1_data, 32'd0);
        next_stalled = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            issue(t_ins[i], 32'h0000_0400 + 32'(i * 4), 1'b0, 4'd0);
            check($sformatf("tbl%0d_exception", i), 32'(decode_exception), 32'(t_exc[i]));
            check($sformatf("tbl%0d_cause", i), 32'(decode_trap_cause), t_exc[i] ? 32'd2 : 32'd0);
            check($sformatf("tbl%0d_jump", i), 32'(decode_is_jump), 32'(t_jmp[i]));
            check($sformatf("tbl%0d_reg_write", i), 32'(decode_is_reg_write), 32'(t_rw[i]));
        end
        tick();

        // Fetch fault forwarded
        issue(32'h0070_0293, 32'h8000_0010, 1'b1, 4'd1);
        check("ffault_exception", 32'(decode_exception), 32'd1);
        check("ffault_cause",     32'(decode_trap_cause), 32'd1);
        check("ffault_addr",      decode_instruction_addr, 32'h8000_0010);
        check("ffault_instr",     decode_original_instruction, 32'h0070_0293);
        check("ffault_reg_write", 32'(decode_is_reg_write), 32'd0);

        // Flush alongside a valid fetch word
        issue(32'h0000_0000, 32'h0000_0500, 1'b0, 4'd0);
        exec_pipeline_flush = 1'b1;
        issue(32'h0070_0293, 32'h0000_0600, 1'b0, 4'd0);
        exec_pipeline_flush = 1'b0;
        check("flush_stall_next", 32'(stall_next), 32'd1);
        check("flush_exception",  32'(decode_exception), 32'd0);
        tick();
        check("flush_dropped", 32'(stall_next), 32'd1);

        // MULH x1,x2,x3 with both operands -1
        wb(5'd2, 32'hFFFF_FFFF);
        wb(5'd3, 32'hFFFF_FFFF);
        issue(32'h0231_10B3, 32'h0000_0700, 1'b0, 4'd0);
`ifdef DECODE_MULDIV_EN
        check("mulh_exception", 32'(decode_exception), 32'd0);
        check("mulh_rs1_sign",  32'(rs1_mul_sign), 32'd1);
        check("mulh_rs2_sign",  32'(rs2_mul_sign), 32'd1);
        check("mulh_reg_write", 32'(decode_is_reg_write), 32'd1);
`else
        check("mulh_exception", 32'(decode_exception), 32'd1);
        check("mulh_cause",     32'(decode_trap_cause), 32'd2);
        check("mulh_rs1_sign",  32'(rs1_mul_sign), 32'd0);
        check("mulh_rs2_sign",  32'(rs2_mul_sign), 32'd0);
`endif
        tick();

        // Async reset in the middle of a hold, sampled before the next edge
        next_stalled = 1'b1;
        issue(32'h0070_0293, 32'h0000_0800, 1'b0, 4'd0);
        tick();
        check("pre_arst_valid", 32'(stall_next), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall_next", 32'(stall_next), 32'd1);
        check("arst_stall_prev", 32'(stall_prev), 32'd0);
        check("arst_instr",      decode_original_instruction, 32'd0);
        check("arst_rd",         32'(rd), 32'd0);
        check("arst_i_imm",      32'(i_imm), 32'd0);
        check("arst_addr",       decode_instruction_addr, 32'd0);
        #3 rst_n = 1'b1;
        next_stalled = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
